truth_table_analyzer: RTL and testbench

Sequential consumer of the truth tables that our function modules produce. It accepts a function's output column one row at a time (row 0 to row 2^N-1, with the input vector equal to the row index), stores it, and then streams out the canonical term lists: first every minterm index (the SoP terms), then every maxterm index (the PoS terms). It sits after a stimulus/evaluation stage and lets benches check SoP/PoS forms automatically instead of by reading printed tables.

---
 rtl/truth_table_analyzer.sv | 123 ++++++++++++
 tb/tb_truth_table_analyzer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_analyzer.sv
// Captures a 2^N-row truth table one row per accepted beat, then streams minterm indices followed by maxterm indices.
// Latency: one scan row per cycle; out_* are decoded from registered state only. Backpressure: out_ready low holds the presented term.
module truth_table_analyzer #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_bit,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_index,
    output logic         out_kind,
    output logic         out_last,
    output logic         busy,
    output logic [N:0]   ones_count,
    output logic         const_one,
    output logic         const_zero
);

    localparam int             DEPTH     = 1 << N;
    localparam logic [N-1:0]   MAX_ROW   = N'(DEPTH - 1);
    localparam logic [N:0]     LAST_TERM = (N + 1)'(DEPTH - 1);
    localparam logic [N:0]     FULL_CNT  = (N + 1)'(DEPTH);

    typedef enum logic [1:0] {
        CAPTURE  = 2'd0,
        SCAN_MIN = 2'd1,
        SCAN_MAX = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DEPTH-1:0] tbl;
    logic [DEPTH-1:0] tbl_nxt;
    logic [N-1:0]     wr_ptr;
    logic [N-1:0]     ptr;
    logic [N:0]       emitted;
    logic [N:0]       ones_nxt;
    logic             cur_bit;
    logic             accept;
    logic             advance;
    logic             fire;
    logic             row_last;
    logic             ptr_last;

    always_comb begin
        in_ready  = (state == CAPTURE);
        busy      = (state != CAPTURE);
        cur_bit   = tbl[ptr];
        out_valid = ((state == SCAN_MIN) && cur_bit) || ((state == SCAN_MAX) && !cur_bit);
        out_kind  = out_valid && (state == SCAN_MIN);
        out_index = out_valid ? ptr : '0;
        out_last  = out_valid && (emitted == LAST_TERM);
        fire      = out_valid && out_ready;
        // Rows that do not match the current scan kind are skipped without waiting on the consumer.
        advance   = busy && (!out_valid || out_ready);
        accept    = in_ready && in_valid;
        row_last  = (wr_ptr == MAX_ROW);
        ptr_last  = (ptr == MAX_ROW);
    end

    // Status is computed on the table as it will look after the final row lands.
    always_comb begin
        tbl_nxt         = tbl;
        tbl_nxt[wr_ptr] = in_bit;
        ones_nxt        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ones_nxt = ones_nxt + (N + 1)'(tbl_nxt[i]);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CAPTURE:  if (accept && row_last) state_nxt = SCAN_MIN;
            SCAN_MIN: if (advance && ptr_last) state_nxt = SCAN_MAX;
            SCAN_MAX: if (advance && ptr_last) state_nxt = CAPTURE;
            default:  state_nxt = CAPTURE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CAPTURE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            ptr        <= '0;
            emitted    <= '0;
            ones_count <= '0;
            const_one  <= 1'b0;
            const_zero <= 1'b0;
        end else begin
            if (accept) begin
                tbl    <= tbl_nxt;
                wr_ptr <= wr_ptr + N'(1);
                if (row_last) begin
                    ones_count <= ones_nxt;
                    const_one  <= (ones_nxt == FULL_CNT);
                    const_zero <= (ones_nxt == '0);
                    ptr        <= '0;
                    wr_ptr     <= '0;
                    emitted    <= '0;
                end
            end
            // ptr wraps to zero naturally when the last row of each scan advances.
            if (advance) begin
                ptr <= ptr + N'(1);
            end
            if (fire) begin
                emitted <= emitted + (N + 1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_truth_table_analyzer.sv
// Scoreboarded bench for truth_table_analyzer: a table-level model queues the expected term stream, a monitor checks every handshake.
module tb_truth_table_analyzer;

    localparam int N     = 3;
    localparam int DEPTH = 1 << N;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic         in_bit;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_index;
    logic         out_kind;
    logic         out_last;
    logic         busy;
    logic [N:0]   ones_count;
    logic         const_one;
    logic         const_zero;

    truth_table_analyzer #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bit     (in_bit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_index  (out_index),
        .out_kind   (out_kind),
        .out_last   (out_last),
        .busy       (busy),
        .ones_count (ones_count),
        .const_one  (const_one),
        .const_zero (const_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int kind;
        int last;
    } term_t;

    term_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Canonical SoP list (ascending minterms) then PoS list (ascending maxterms); the final term carries last.
    function automatic void expect_table(input logic [63:0] t);
        term_t e;
        for (int k = 1; k >= 0; k--) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (int'(t[i]) == k) begin
                    e.idx  = i;
                    e.kind = k;
                    e.last = 0;
                    sb.push_back(e);
                end
            end
        end
        e      = sb.pop_back();
        e.last = 1;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin : monitor
        term_t e;
        if (!reset && out_valid && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_term: got (kind %0d, idx %0d, last %0d), expected no term",
                         out_kind, out_index, out_last);
            end else begin
                e = sb.pop_front();
                if (out_index != N'(e.idx) || int'(out_kind) != e.kind || int'(out_last) != e.last) begin
                    n_err++;
                    $display("FAIL term: got (kind %0d, idx %0d, last %0d), expected (kind %0d, idx %0d, last %0d)",
                             out_kind, out_index, out_last, e.kind, e.idx, e.last);
                end
            end
        end
    end

    task automatic send_table(input logic [63:0] t, input bit gaps);
        int ones;
        chk("in_ready_capture", int'(in_ready), 1);
        for (int i = 0; i < DEPTH; i++) begin
            if (gaps && i > 0) begin
                in_valid = 1'b0;
                in_bit   = 1'($urandom);
                @(posedge clk); #1;
            end
            if (i == DEPTH - 1) expect_table(t);
            in_valid = 1'b1;
            in_bit   = t[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        ones = $countones(t[DEPTH-1:0]);
        chk("busy_after_capture", int'(busy), 1);
        chk("ones_count", int'(ones_count), ones);
        chk("const_one", int'(const_one), int'(ones == DEPTH));
        chk("const_zero", int'(const_zero), int'(ones == 0));
    endtask

    // Drives out_ready through one scan; bp stalls the (1,5) term for three cycles.
    task automatic run_scan(input bit rnd_ready, input bit bp, input bit noise, input int exp_cycles);
        int cycles  = 0;
        int bp_left = 3;
        bit stalled = 1'b0;
        while (busy && cycles < 200) begin
            if (stalled) begin
                chk("bp_valid", int'(out_valid), 1);
                chk("bp_index", int'(out_index), 5);
                chk("bp_kind", int'(out_kind), 1);
            end
            stalled = 1'b0;
            if (bp && bp_left > 0 && out_valid && out_index == 3'd5 && out_kind) begin
                out_ready = 1'b0;
                bp_left--;
                stalled = 1'b1;
            end else begin
                out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (noise) begin
                in_valid = 1'b1;
                in_bit   = 1'($urandom);
            end
            cycles++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (cycles >= 200) chk("scan_timeout", cycles, 0);
        if (exp_cycles >= 0) chk("scan_cycles", cycles, exp_cycles);
        if (bp) chk("bp_applied", bp_left, 0);
        chk("in_ready_after_scan", int'(in_ready), 1);
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [63:0] t;
        int          n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_index", int'(out_index), 0);
        chk("rst_out_kind", int'(out_kind), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ones_count", int'(ones_count), 0);
        chk("rst_const_one", int'(const_one), 0);
        chk("rst_const_zero", int'(const_zero), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        out_ready = 1'b1;

        // f = x&(~y|z): rows 4,5,7 are ones.
        send_table(64'hB0, 1'b0);
        run_scan(1'b0, 1'b0, 1'b0, 16);
        send_table(64'hFF, 1'b0);
        run_scan(1'b0, 1'b0, 1'b0, 16);
        send_table(64'h00, 1'b0);
        run_scan(1'b0, 1'b0, 1'b0, 16);
        send_table(64'hB0, 1'b0);
        run_scan(1'b0, 1'b1, 1'b0, 19);
        t = 64'($urandom);
        send_table(t, 1'b1);
        run_scan(1'b0, 1'b0, 1'b1, 16);

        send_table(64'hB0, 1'b0);
        n = 0;
        while (!(out_valid && out_index == 3'd5 && out_kind) && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        chk("reach_idx5_timeout", int'(n >= 40), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_ones_count", int'(ones_count), 0);
        chk("midrst_const_one", int'(const_one), 0);
        chk("midrst_const_zero", int'(const_zero), 0);
        send_table(64'h01, 1'b0);
        run_scan(1'b0, 1'b0, 1'b0, 16);

        for (int r = 0; r < 6; r++) begin
            t = 64'($urandom);
            send_table(t, 1'($urandom));
            run_scan(1'b1, 1'b0, 1'($urandom), -1);
        end

        chk("sb_empty_end", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
